// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input, WIDTH-bit valid/ready multiplexer with a single
// output register. Channels are picked either by a fixed select (mode=0) or
// round-robin among the valid inputs (mode=1).
// Optional packet locking is enabled by defining STREAM_MUX_PKT_LOCK_EN:
// this adds in_last/out_last, and a channel keeps the grant until it sends
// its last beat.

// One input lane: produces the handshake and a masked copy of the word, so
// the top level can build a one-hot AND-OR data mux.
module stream_mux_lane #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  input  logic             hit,
  input  logic             take,
  output logic             ready,
  output logic [WIDTH-1:0] word_sel
);
  assign ready    = take & hit;
  assign word_sel = hit ? word : '0;
endmodule

module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  input  logic             mode,
  input  logic [SW-1:0]    sel,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [SW-1:0]               rr_ptr;
  logic                        load;
  logic                        take;
  logic                        gnt_ok;
  logic [SW-1:0]               gnt_idx;
  logic [N-1:0]                gnt;
  logic                        found;
  logic [N-1:0][WIDTH-1:0]     lane_word;
  logic [WIDTH-1:0]            word;
  logic                        xfer;
  logic                        beat_last;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_ch;
  assign beat_last = |(in_last & gnt);
`else
  assign beat_last = 1'b1;
`endif

  // The output register can take a new word when empty or draining.
  // Reset also blocks every handshake so nothing is acknowledged while held.
  assign load = !out_valid || out_ready;
  assign take = load && !rst;

  // Arbitration: pick at most one valid channel (lock, fixed select or RR scan).
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    found   = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (locked) begin
      for (int i = 0; i < N; i++) begin
        if (lock_ch == SW'(i) && in_valid[i]) begin
          gnt_ok  = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else
`endif
    if (!mode) begin
      // sel values at or above N match no lane and grant nothing
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i) && in_valid[i]) begin
          gnt_ok  = 1'b1;
          gnt_idx = SW'(i);
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && in_valid[(int'(rr_ptr) + k) % N]) begin
          found   = 1'b1;
          gnt_ok  = 1'b1;
          gnt_idx = SW'((int'(rr_ptr) + k) % N);
        end
      end
    end
  end

  // Expand the winning index to a one-hot grant vector.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++)
      gnt[i] = gnt_ok && (gnt_idx == SW'(i));
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    stream_mux_lane #(.WIDTH(WIDTH)) u_lane (
      .word     (in_data[i*WIDTH +: WIDTH]),
      .hit      (gnt[i]),
      .take     (take),
      .ready    (in_ready[i]),
      .word_sel (lane_word[i])
    );
  end

  // OR together the masked lane words; at most one is non-zero.
  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++)
      word = word | lane_word[i];
  end

  assign xfer = take && gnt_ok;

  // Output register: capture on input transfer, empty on an idle load, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
`endif
    end else if (xfer) begin
      out_data  <= word;
      out_src   <= gnt_idx;
      out_valid <= 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
      out_last  <= beat_last;
`endif
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the winner on a finished RR transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rr_ptr <= '0;
    else if (xfer && mode && beat_last)
      rr_ptr <= (gnt_idx == SW'(N-1)) ? '0 : gnt_idx + SW'(1);
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  // Packet lock: held from a non-last beat until the channel's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (xfer) begin
      locked  <= !beat_last;
      lock_ch <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr (WIDTH=8, N=4): vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
module tb_stream_mux_rr;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic           mode = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_valid;
  logic           out_ready = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]   in_last = '1;
  logic           out_last;
`endif

  stream_mux_rr #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_PKT_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #2;
    tick();
    rst = 1'b0;
  endtask

  // Reference: which channel the rules pick, or -1 for none.
  function automatic int ref_grant(input bit md, input int s, input logic [N-1:0] v, input int rr);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 0; k < N; k++)
      if (v[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic          md;
    logic [SW-1:0] s;
    logic [N-1:0]  v;
    logic          ordy;
    logic [N-1:0]  exp_rdy;
    logic          exp_ov;
    logic [SW-1:0] exp_src;
    logic [W-1:0]  exp_data;
  } vec_t;

  vec_t vt[11];

  // model state for the randomized phase
  int         m_rr;
  bit         m_ov;
  logic [W-1:0] m_data;
  int         m_src;

  initial begin
    // -------- vector table (starts from reset state, ch data 11/22/A5/44)
    vt[0]  = '{1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};
    vt[1]  = '{1'b0, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 2'd2, 8'hA5};
    vt[2]  = '{1'b0, 2'd1, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 8'h22};
    vt[3]  = '{1'b0, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h22};
    vt[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    vt[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22};
    vt[6]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    vt[7]  = '{1'b1, 2'd0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11};
    vt[8]  = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44};
    vt[9]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'h44};
    vt[10] = '{1'b1, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5};

    // -------- reset state (inputs valid while reset is held)
    in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
    in_valid = 4'b1111;
    #2;
    check("reset_in_ready", 32'(in_ready), 32'h0);
    tick();
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_out_data", 32'(out_data), 32'h0);
    check("reset_out_src", 32'(out_src), 32'h0);
    rst = 1'b0;

    // -------- table-driven vectors
    for (int i = 0; i < 11; i++) begin
      mode = vt[i].md; sel = vt[i].s; in_valid = vt[i].v; out_ready = vt[i].ordy;
      #2;
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].exp_rdy));
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vt[i].exp_ov));
      check($sformatf("vec%0d_out_src", i), 32'(out_src), 32'(vt[i].exp_src));
      check($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vt[i].exp_data));
    end

    // -------- round-robin, all valid: 0,1,2,3,0 back to back
    do_reset();
    mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rr_all_src%0d", k), 32'(out_src), 32'(k % N));
      check($sformatf("rr_all_valid%0d", k), 32'(out_valid), 32'h1);
    end

    // -------- ch1/ch3 valid, stall 3 cycles, then alternate
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b0;
    tick();
    check("stall_first_src", 32'(out_src), 32'h1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall_in_ready%0d", k), 32'(in_ready), 32'h0);
      tick();
      check($sformatf("stall_src%0d", k), 32'(out_src), 32'h1);
      check($sformatf("stall_data%0d", k), 32'(out_data), 32'h22);
      check($sformatf("stall_valid%0d", k), 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("alt_src%0d", k), 32'(out_src), (k % 2 == 0) ? 32'h3 : 32'h1);
    end

    // -------- asynchronous reset mid-stream, checked before any edge
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    check("async_rst_out_data", 32'(out_data), 32'h0);
    check("async_rst_out_src", 32'(out_src), 32'h0);
    check("async_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;

`ifdef STREAM_MUX_PKT_LOCK_EN
    // -------- packet lock: ch0 three beats, ch1 waits
    do_reset();
    mode = 1'b1; in_valid = 4'b0011; out_ready = 1'b1; in_last = 4'b1110;
    #2;
    check("lock_b1_ready", 32'(in_ready), 32'h1);
    tick();
    check("lock_b1_src", 32'(out_src), 32'h0);
    check("lock_b1_last", 32'(out_last), 32'h0);
    mode = 1'b0; sel = 2'd1;
    #2;
    check("lock_b2_ready", 32'(in_ready), 32'h1);
    tick();
    check("lock_b2_src", 32'(out_src), 32'h0);
    mode = 1'b1; in_last = 4'b1111;
    tick();
    check("lock_b3_src", 32'(out_src), 32'h0);
    check("lock_b3_last", 32'(out_last), 32'h1);
    tick();
    check("lock_next_src", 32'(out_src), 32'h1);
`endif

    // -------- randomized run against the reference model
    do_reset();
    m_rr = 0; m_ov = 1'b0; m_data = '0; m_src = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      bit ld;
      logic [N-1:0] exp_rdy;
      mode      = 1'($urandom_range(0, 1));
      sel       = SW'($urandom_range(0, N-1));
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = N*W'({$urandom, $urandom});
      ld = !m_ov || out_ready;
      g  = ref_grant(mode, int'(sel), in_valid, m_rr);
      exp_rdy = (ld && g >= 0) ? N'(1 << g) : '0;
      #2;
      check($sformatf("rand%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy));
      if (ld && g >= 0) begin
        m_data = in_data[g*W +: W];
        m_src  = g;
        m_ov   = 1'b1;
        if (mode) m_rr = (g + 1) % N;
      end else if (ld) begin
        m_ov = 1'b0;
      end
      tick();
      check($sformatf("rand%0d_out_valid", c), 32'(out_valid), 32'(m_ov));
      check($sformatf("rand%0d_out_src", c), 32'(out_src), 32'(m_src));
      check($sformatf("rand%0d_out_data", c), 32'(out_data), 32'(m_data));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
